// File: rtl/seq_detector_param.sv
// Bit-serial Mealy sequence detector with a runtime-loadable pattern and length,
// run-time overlap selection and a saturating match counter.
module seq_detector_param #(
    parameter int unsigned          MAX_W         = 8,
    parameter int unsigned          CNT_W         = 8,
    parameter logic [MAX_W-1:0]     RESET_PATTERN = MAX_W'(8'b0000_1101),
    parameter int unsigned          RESET_LEN     = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         en,
    input  logic                         in,
    input  logic                         overlap,
    input  logic                         cfg_load,
    input  logic [MAX_W-1:0]             cfg_pattern,
    input  logic [$clog2(MAX_W+1)-1:0]   cfg_len,
    input  logic                         clr_count,
    output logic                         out,
    output logic [CNT_W-1:0]             match_count
);

    localparam int unsigned LW = $clog2(MAX_W + 1);
    localparam int unsigned VW = $clog2(MAX_W);
    localparam logic [VW-1:0] VMAX = VW'(MAX_W - 1);

    logic [MAX_W-1:0] pat_q, pat_d;
    logic [LW-1:0]    len_q, len_d;
    logic [MAX_W-2:0] hist_q, hist_d;
    logic [VW-1:0]    vcnt_q, vcnt_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [MAX_W-1:0] window;
    logic [MAX_W-1:0] mask;
    logic             hit;
    logic             armed;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pat_q  <= RESET_PATTERN;
            len_q  <= LW'(RESET_LEN);
            hist_q <= '0;
            vcnt_q <= '0;
            cnt_q  <= '0;
        end else begin
            pat_q  <= pat_d;
            len_q  <= len_d;
            hist_q <= hist_d;
            vcnt_q <= vcnt_d;
            cnt_q  <= cnt_d;
        end
    end

    // Window compare: only the lower len_q bits of {hist, in} take part
    always_comb begin
        window = {hist_q, in};
        mask   = '0;
        for (int i = 0; i < MAX_W; i++) begin
            mask[i] = (i < int'(len_q));
        end
        hit   = (((window ^ pat_q) & mask) == '0);
        // vcnt >= len-1, written without subtraction
        armed = ((LW'(vcnt_q) + LW'(1)) >= len_q);
    end

    // Next-state logic
    always_comb begin
        pat_d  = pat_q;
        len_d  = len_q;
        hist_d = hist_q;
        vcnt_d = vcnt_q;
        cnt_d  = cnt_q;

        if (cfg_load) begin
            pat_d  = cfg_pattern;
            vcnt_d = '0;
            if (cfg_len == '0) begin
                len_d = LW'(1);
            end else if (cfg_len > LW'(MAX_W)) begin
                len_d = LW'(MAX_W);
            end else begin
                len_d = cfg_len;
            end
        end else if (en) begin
            hist_d = window[MAX_W-2:0];
            if (out && !overlap) begin
                vcnt_d = '0;
            end else if (vcnt_q != VMAX) begin
                vcnt_d = vcnt_q + VW'(1);
            end
        end

        if (clr_count) begin
            cnt_d = '0;
        end else if (out && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Outputs
    always_comb begin
        out         = en & ~cfg_load & ~rst & armed & hit;
        match_count = cnt_q;
    end

endmodule
